// File: rtl/pipelined_control_unit.sv
// Control and hazard unit for the 5-stage RV32I pipeline.
// Decodes in ID, carries controls to WB, resolves branches in EX.
module pipelined_control_unit #(
    parameter int INST_WIDTH   = 32,
    parameter int IMMSEL_WIDTH = 3,
    parameter int ALUSEL_WIDTH = 4,
    parameter bit FWD_EN       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [INST_WIDTH-1:0]   inst_id,
    input  logic                    BrEq,
    input  logic                    BrLT,
    output logic [IMMSEL_WIDTH-1:0] ImmSel_id,
    output logic [ALUSEL_WIDTH-1:0] ALUSel_ex,
    output logic [1:0]              ASel_ex,
    output logic                    BSel_ex,
    output logic                    BrUn_ex,
    output logic                    PCSel_ex,
    output logic [1:0]              fwd_a_ex,
    output logic [1:0]              fwd_b_ex,
    output logic                    MemRW_mem,
    output logic [1:0]              WBSel_mem,
    output logic [1:0]              WBSel_wb,
    output logic                    RegWEn_wb,
    output logic [4:0]              rd_wb,
    output logic                    stall,
    output logic                    flush
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic                    regwen;
        logic                    memrw;
        logic                    branch;
        logic                    jump;
        logic                    is_load;
        logic                    brun;
        logic                    bsel;
        logic [1:0]              asel;
        logic [1:0]              wbsel;
        logic [2:0]              funct3;
        logic [ALUSEL_WIDTH-1:0] alusel;
        logic [4:0]              rd;
        logic [4:0]              rs1;
        logic [4:0]              rs2;
    } id_ex_t;

    typedef struct packed {
        logic       regwen;
        logic       memrw;
        logic [1:0] wbsel;
        logic [4:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic       regwen;
        logic [1:0] wbsel;
        logic [4:0] rd;
    } mem_wb_t;

    id_ex_t  dec;
    id_ex_t  id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;

    logic [6:0]              opcode;
    logic [2:0]              funct3;
    logic [4:0]              rd_f;
    logic                    alt;
    logic                    wr;
    logic                    use1;
    logic                    use2;
    logic [ALUSEL_WIDTH-1:0] alu_fn;
    logic                    hazard;
    logic                    ld_hit;
    logic                    so_hit;
    logic                    cond;
    logic                    unused_bits;

    assign opcode      = inst_id[6:0];
    assign funct3      = inst_id[14:12];
    assign rd_f        = inst_id[11:7];
    assign unused_bits = &{1'b0, inst_id[INST_WIDTH-1:31], inst_id[29:25]};

    always_comb begin
        alu_fn = '0;
        case (funct3)
            3'b000:  alu_fn = alt ? ALUSEL_WIDTH'(1) : ALUSEL_WIDTH'(0);
            3'b001:  alu_fn = ALUSEL_WIDTH'(2);
            3'b010:  alu_fn = ALUSEL_WIDTH'(3);
            3'b011:  alu_fn = ALUSEL_WIDTH'(4);
            3'b100:  alu_fn = ALUSEL_WIDTH'(5);
            3'b101:  alu_fn = alt ? ALUSEL_WIDTH'(7) : ALUSEL_WIDTH'(6);
            3'b110:  alu_fn = ALUSEL_WIDTH'(8);
            default: alu_fn = ALUSEL_WIDTH'(9);
        endcase
    end

    always_comb begin
        dec       = '0;
        ImmSel_id = '0;
        wr        = 1'b0;
        use1      = 1'b0;
        use2      = 1'b0;
        alt       = 1'b0;
        unique case (1'b1)
            (opcode == OP_R): begin
                alt        = inst_id[30];
                dec.alusel = alu_fn;
                dec.wbsel  = 2'd1;
                wr         = 1'b1;
                use1       = 1'b1;
                use2       = 1'b1;
            end
            (opcode == OP_I): begin
                alt        = inst_id[30] & (funct3 == 3'b101);
                dec.alusel = alu_fn;
                dec.bsel   = 1'b1;
                dec.wbsel  = 2'd1;
                wr         = 1'b1;
                use1       = 1'b1;
            end
            (opcode == OP_LW): begin
                dec.bsel    = 1'b1;
                dec.is_load = 1'b1;
                wr          = 1'b1;
                use1        = 1'b1;
            end
            (opcode == OP_SW): begin
                ImmSel_id = IMMSEL_WIDTH'(1);
                dec.bsel  = 1'b1;
                dec.memrw = 1'b1;
                use1      = 1'b1;
                use2      = 1'b1;
            end
            (opcode == OP_BR): begin
                ImmSel_id  = IMMSEL_WIDTH'(2);
                dec.branch = 1'b1;
                dec.brun   = funct3[1];
                dec.funct3 = funct3;
                dec.asel   = 2'd1;
                dec.bsel   = 1'b1;
                use1       = 1'b1;
                use2       = 1'b1;
            end
            (opcode == OP_JAL): begin
                ImmSel_id = IMMSEL_WIDTH'(4);
                dec.jump  = 1'b1;
                dec.asel  = 2'd1;
                dec.bsel  = 1'b1;
                dec.wbsel = 2'd2;
                wr        = 1'b1;
            end
            (opcode == OP_JALR): begin
                dec.jump  = 1'b1;
                dec.bsel  = 1'b1;
                dec.wbsel = 2'd2;
                wr        = 1'b1;
                use1      = 1'b1;
            end
            (opcode == OP_LUI): begin
                ImmSel_id = IMMSEL_WIDTH'(3);
                dec.asel  = 2'd2;
                dec.bsel  = 1'b1;
                dec.wbsel = 2'd1;
                wr        = 1'b1;
            end
            (opcode == OP_AUIPC): begin
                ImmSel_id = IMMSEL_WIDTH'(3);
                dec.asel  = 2'd1;
                dec.bsel  = 1'b1;
                dec.wbsel = 2'd1;
                wr        = 1'b1;
            end
            default: ;
        endcase
        // Writes to x0 are dropped here so no later stage needs an rd != 0 check
        dec.regwen = wr & (rd_f != 5'd0);
        dec.rd     = dec.regwen ? rd_f : 5'd0;
        dec.rs1    = use1 ? inst_id[19:15] : 5'd0;
        dec.rs2    = use2 ? inst_id[24:20] : 5'd0;
    end

    assign ld_hit = id_ex.is_load & (id_ex.rd != 5'd0) &
                    ((dec.rs1 == id_ex.rd) | (dec.rs2 == id_ex.rd));

    assign so_hit = (id_ex.regwen &
                     ((dec.rs1 == id_ex.rd) | (dec.rs2 == id_ex.rd))) |
                    (ex_mem.regwen &
                     ((dec.rs1 == ex_mem.rd) | (dec.rs2 == ex_mem.rd)));

    assign hazard = FWD_EN ? ld_hit : so_hit;

    always_comb begin
        cond = 1'b0;
        case (id_ex.funct3)
            3'b000:         cond = BrEq;
            3'b001:         cond = ~BrEq;
            3'b100, 3'b110: cond = BrLT;
            3'b101, 3'b111: cond = ~BrLT;
            default:        cond = 1'b0;
        endcase
    end

    assign PCSel_ex = id_ex.jump | (id_ex.branch & cond);
    assign flush    = PCSel_ex;
    assign stall    = hazard & ~flush;

    always_comb begin
        fwd_a_ex = 2'b00;
        fwd_b_ex = 2'b00;
        if (FWD_EN) begin
            if (ex_mem.regwen && ex_mem.rd == id_ex.rs1)
                fwd_a_ex = 2'b01;
            else if (mem_wb.regwen && mem_wb.rd == id_ex.rs1)
                fwd_a_ex = 2'b10;
            if (ex_mem.regwen && ex_mem.rd == id_ex.rs2)
                fwd_b_ex = 2'b01;
            else if (mem_wb.regwen && mem_wb.rd == id_ex.rs2)
                fwd_b_ex = 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else begin
            id_ex         <= (hazard | flush) ? '0 : dec;
            ex_mem.regwen <= id_ex.regwen;
            ex_mem.memrw  <= id_ex.memrw;
            ex_mem.wbsel  <= id_ex.wbsel;
            ex_mem.rd     <= id_ex.rd;
            mem_wb.regwen <= ex_mem.regwen;
            mem_wb.wbsel  <= ex_mem.wbsel;
            mem_wb.rd     <= ex_mem.rd;
        end
    end

    assign ALUSel_ex = id_ex.alusel;
    assign ASel_ex   = id_ex.asel;
    assign BSel_ex   = id_ex.bsel;
    assign BrUn_ex   = id_ex.brun;
    assign MemRW_mem = ex_mem.memrw;
    assign WBSel_mem = ex_mem.wbsel;
    assign WBSel_wb  = mem_wb.wbsel;
    assign RegWEn_wb = mem_wb.regwen;
    assign rd_wb     = mem_wb.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit.
// Instance 0 forwards, instance 1 is stall-only.
module tb_pipelined_control_unit;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADD3    = 32'h002081B3;
    localparam logic [31:0] SUB4    = 32'h40118233;
    localparam logic [31:0] OR5     = 32'h0041E2B3;
    localparam logic [31:0] LW5     = 32'h0000A283;
    localparam logic [31:0] ADD6    = 32'h00510333;
    localparam logic [31:0] BEQ     = 32'h00208463;
    localparam logic [31:0] BNE     = 32'h00209463;
    localparam logic [31:0] BLTU    = 32'h0020E463;
    localparam logic [31:0] JAL1    = 32'h008000EF;
    localparam logic [31:0] ADDI7   = 32'h00100393;
    localparam logic [31:0] ADDI3   = 32'h00100193;
    localparam logic [31:0] ADD4    = 32'h00318233;
    localparam logic [31:0] ADDI_X0 = 32'h00100013;
    localparam logic [31:0] ADD_X1  = 32'h000000B3;
    localparam logic [31:0] SW      = 32'h0020A023;
    localparam logic [31:0] ILL     = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst_id = NOP;
    logic        br_eq = 1'b0;
    logic        br_lt = 1'b0;

    logic [2:0] imm_sel [2];
    logic [3:0] alu_sel [2];
    logic [1:0] a_sel   [2];
    logic       b_sel   [2];
    logic       br_un   [2];
    logic       pc_sel  [2];
    logic [1:0] fwd_a   [2];
    logic [1:0] fwd_b   [2];
    logic       mem_rw  [2];
    logic [1:0] wb_mem  [2];
    logic [1:0] wb_wb   [2];
    logic       reg_wen [2];
    logic [4:0] rd      [2];
    logic       stl     [2];
    logic       fls     [2];

    pipelined_control_unit #(.FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id),
        .BrEq(br_eq), .BrLT(br_lt),
        .ImmSel_id(imm_sel[0]), .ALUSel_ex(alu_sel[0]),
        .ASel_ex(a_sel[0]), .BSel_ex(b_sel[0]),
        .BrUn_ex(br_un[0]), .PCSel_ex(pc_sel[0]),
        .fwd_a_ex(fwd_a[0]), .fwd_b_ex(fwd_b[0]),
        .MemRW_mem(mem_rw[0]), .WBSel_mem(wb_mem[0]),
        .WBSel_wb(wb_wb[0]), .RegWEn_wb(reg_wen[0]),
        .rd_wb(rd[0]), .stall(stl[0]), .flush(fls[0])
    );

    pipelined_control_unit #(.FWD_EN(1'b0)) u_stl (
        .clk(clk), .rst_n(rst_n), .inst_id(inst_id),
        .BrEq(br_eq), .BrLT(br_lt),
        .ImmSel_id(imm_sel[1]), .ALUSel_ex(alu_sel[1]),
        .ASel_ex(a_sel[1]), .BSel_ex(b_sel[1]),
        .BrUn_ex(br_un[1]), .PCSel_ex(pc_sel[1]),
        .fwd_a_ex(fwd_a[1]), .fwd_b_ex(fwd_b[1]),
        .MemRW_mem(mem_rw[1]), .WBSel_mem(wb_mem[1]),
        .WBSel_wb(wb_wb[1]), .RegWEn_wb(reg_wen[1]),
        .rd_wb(rd[1]), .stall(stl[1]), .flush(fls[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {
        S_IMM, S_ALU, S_ASEL, S_BSEL, S_BRUN, S_PCSEL, S_FWDA, S_FWDB,
        S_MEMRW, S_WBM, S_WBW, S_REGWEN, S_RD, S_STALL, S_FLUSH
    } sig_e;

    typedef struct {
        int          cyc;
        int          d;
        sig_e        s;
        logic [31:0] v;
        string       name;
    } exp_t;

    exp_t q[$];
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] peek(int d, sig_e s);
        case (s)
            S_IMM:    return 32'(imm_sel[d]);
            S_ALU:    return 32'(alu_sel[d]);
            S_ASEL:   return 32'(a_sel[d]);
            S_BSEL:   return 32'(b_sel[d]);
            S_BRUN:   return 32'(br_un[d]);
            S_PCSEL:  return 32'(pc_sel[d]);
            S_FWDA:   return 32'(fwd_a[d]);
            S_FWDB:   return 32'(fwd_b[d]);
            S_MEMRW:  return 32'(mem_rw[d]);
            S_WBM:    return 32'(wb_mem[d]);
            S_WBW:    return 32'(wb_wb[d]);
            S_REGWEN: return 32'(reg_wen[d]);
            S_RD:     return 32'(rd[d]);
            S_STALL:  return 32'(stl[d]);
            default:  return 32'(fls[d]);
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endfunction

    // Queue is kept sorted by target cycle
    task automatic expect_at(int d, int off, sig_e s, logic [31:0] v,
                             string name);
        exp_t e;
        int   i;
        e.cyc  = cyc + off;
        e.d    = d;
        e.s    = s;
        e.v    = v;
        e.name = name;
        i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check(e.name, peek(e.d, e.s), e.v);
            end
        end
    end

    task automatic issue(logic [31:0] i);
        @(posedge clk);
        #1;
        inst_id = i;
        br_eq   = 1'b0;
        br_lt   = 1'b0;
    endtask

    task automatic pad(int n);
        for (int k = 0; k < n; k++) issue(NOP);
    endtask

    task automatic check_all_zero(string tag);
        for (int d = 0; d < 2; d++)
            for (int s = 0; s <= int'(S_FLUSH); s++)
                check($sformatf("%s_d%0d_%s", tag, d, sig_e'(s)),
                      peek(d, sig_e'(s)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        pad(4);

        // EX/MEM and WB forwarding, MEM priority
        issue(ADD3);
        expect_at(0, 1, S_ALU, 0, "add_alu");
        expect_at(0, 1, S_FWDA, 0, "add_fwd_a");
        expect_at(0, 3, S_REGWEN, 1, "add_wen");
        expect_at(0, 3, S_RD, 3, "add_rd");
        issue(SUB4);
        expect_at(0, 1, S_FWDA, 1, "sub_fwd_a");
        expect_at(0, 1, S_FWDB, 0, "sub_fwd_b");
        expect_at(0, 1, S_ALU, 1, "sub_alu");
        expect_at(0, 3, S_REGWEN, 1, "sub_wen");
        expect_at(0, 3, S_RD, 4, "sub_rd");
        issue(OR5);
        expect_at(0, 1, S_FWDA, 2, "or_fwd_a_wb");
        expect_at(0, 1, S_FWDB, 1, "or_fwd_b_mem");
        expect_at(0, 1, S_ALU, 8, "or_alu");
        pad(4);

        // Load-use
        issue(LW5);
        expect_at(0, 0, S_STALL, 0, "lw_nostall");
        expect_at(0, 0, S_IMM, 0, "lw_imm");
        expect_at(0, 2, S_WBM, 0, "lw_wbsel_mem");
        expect_at(0, 3, S_REGWEN, 1, "lw_wen");
        expect_at(0, 3, S_RD, 5, "lw_rd");
        expect_at(0, 3, S_WBW, 0, "lw_wbsel_wb");
        issue(ADD6);
        expect_at(0, 0, S_STALL, 1, "lu_stall");
        expect_at(0, 1, S_FWDB, 0, "lu_bubble_fwd_b");
        expect_at(0, 1, S_ALU, 0, "lu_bubble_alu");
        expect_at(0, 3, S_REGWEN, 0, "lu_bubble_wen");
        issue(ADD6);
        expect_at(0, 0, S_STALL, 0, "lu_stall_once");
        expect_at(0, 1, S_FWDB, 2, "lu_fwd_b_wb");
        expect_at(0, 1, S_FWDA, 0, "lu_fwd_a");
        expect_at(0, 3, S_REGWEN, 1, "lu_add_wen");
        expect_at(0, 3, S_RD, 6, "lu_add_rd");
        pad(4);

        // Taken BEQ squashes two younger slots
        issue(BEQ);
        expect_at(0, 0, S_IMM, 2, "beq_imm");
        expect_at(0, 1, S_PCSEL, 1, "beq_pcsel");
        expect_at(0, 1, S_FLUSH, 1, "beq_flush");
        expect_at(0, 1, S_STALL, 0, "beq_stall");
        expect_at(0, 1, S_ASEL, 1, "beq_asel");
        expect_at(0, 1, S_BSEL, 1, "beq_bsel");
        expect_at(0, 1, S_BRUN, 0, "beq_brun");
        expect_at(0, 2, S_PCSEL, 0, "beq_bubble_pcsel");
        expect_at(0, 2, S_FLUSH, 0, "beq_flush_once");
        expect_at(0, 3, S_REGWEN, 0, "beq_wen");
        issue(ADDI7);
        br_eq = 1'b1;
        expect_at(0, 3, S_REGWEN, 0, "squash_id_wen");
        issue(NOP);
        br_eq = 1'b1;
        expect_at(0, 3, S_REGWEN, 0, "squash_if_wen");
        pad(4);

        issue(BNE);
        expect_at(0, 1, S_PCSEL, 0, "bne_pcsel");
        expect_at(0, 1, S_FLUSH, 0, "bne_flush");
        issue(NOP);
        br_eq = 1'b1;
        issue(BLTU);
        expect_at(0, 1, S_BRUN, 1, "bltu_brun");
        expect_at(0, 1, S_PCSEL, 1, "bltu_pcsel");
        issue(NOP);
        br_lt = 1'b1;
        pad(4);

        issue(JAL1);
        expect_at(0, 0, S_IMM, 4, "jal_imm");
        expect_at(0, 1, S_PCSEL, 1, "jal_pcsel");
        expect_at(0, 3, S_REGWEN, 1, "jal_wen");
        expect_at(0, 3, S_RD, 1, "jal_rd");
        expect_at(0, 3, S_WBW, 2, "jal_wbsel");
        pad(5);

        // Stall-only instance
        issue(ADDI3);
        expect_at(1, 0, S_STALL, 0, "so_first");
        issue(ADD4);
        expect_at(1, 0, S_STALL, 1, "so_stall_ex");
        expect_at(0, 0, S_STALL, 0, "fwd_no_stall");
        expect_at(1, 1, S_FWDA, 0, "so_fwd_a1");
        expect_at(1, 1, S_FWDB, 0, "so_fwd_b1");
        issue(ADD4);
        expect_at(1, 0, S_STALL, 1, "so_stall_mem");
        expect_at(1, 1, S_FWDA, 0, "so_fwd_a2");
        issue(ADD4);
        expect_at(1, 0, S_STALL, 0, "so_stall_wb");
        expect_at(1, 1, S_FWDA, 0, "so_fwd_a3");
        expect_at(1, 1, S_FWDB, 0, "so_fwd_b3");
        expect_at(1, 3, S_REGWEN, 1, "so_wen");
        expect_at(1, 3, S_RD, 4, "so_rd");
        pad(4);

        // x0 never forwards or stalls
        issue(ADDI_X0);
        expect_at(0, 3, S_REGWEN, 0, "x0_wen");
        issue(ADD_X1);
        expect_at(0, 0, S_STALL, 0, "x0_stall_fwd");
        expect_at(1, 0, S_STALL, 0, "x0_stall_so");
        expect_at(0, 1, S_FWDA, 0, "x0_fwd_a");
        expect_at(0, 1, S_FWDB, 0, "x0_fwd_b");
        pad(4);

        // Illegal opcode behaves as a bubble
        issue(ADDI7);
        expect_at(0, 3, S_REGWEN, 1, "il_addi_wen");
        expect_at(0, 3, S_RD, 7, "il_addi_rd");
        issue(SW);
        expect_at(0, 0, S_IMM, 1, "sw_imm");
        expect_at(0, 2, S_MEMRW, 1, "sw_memrw");
        expect_at(0, 3, S_REGWEN, 0, "sw_wen");
        issue(ILL);
        expect_at(0, 0, S_IMM, 0, "ill_imm");
        expect_at(0, 2, S_MEMRW, 0, "ill_memrw");
        expect_at(0, 3, S_REGWEN, 0, "ill_wen");
        pad(4);

        // Asynchronous reset with a SW in MEM and a write in WB
        issue(ADDI7);
        expect_at(0, 3, S_REGWEN, 1, "pre_rst_wen");
        issue(SW);
        expect_at(0, 2, S_MEMRW, 1, "pre_rst_memrw");
        issue(NOP);
        issue(NOP);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_memrw_d0", 32'(mem_rw[0]), 0);
        check("arst_wen_d0", 32'(reg_wen[0]), 0);
        check("arst_rd_d0", 32'(rd[0]), 0);
        check("arst_memrw_d1", 32'(mem_rw[1]), 0);
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        pad(4);

        guard = 0;
        while (q.size() > 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            $display("FAIL pending: %0d expectations never checked",
                     q.size());
            n_tests += q.size();
            n_fail  += q.size();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Control and hazard unit for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB). It decodes the instruction in ID and carries the control bundle through internal ID/EX, EX/MEM and MEM/WB registers. It resolves branches and jumps in EX and generates load-use stall, wrong-path flush and operand-forwarding selects for the datapath.

## Interface
- INST_WIDTH, 32, instruction width
- IMMSEL_WIDTH, 3, immediate-select width
- ALUSEL_WIDTH, 4, ALU-select width
- FWD_EN, 1, 1 = forwarding enabled; 0 = stall-only hazard resolution (forward selects tied 2'b00)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst_id  in  INST_WIDTH  instruction in ID; the datapath supplies 32'h00000013 (NOP) when IF/ID is flushed
- BrEq, BrLT  in  1 each  branch comparator results for the EX operands
- ImmSel_id  out  IMMSEL_WIDTH  I=0, S=1, B=2, U=3, J=4
- ALUSel_ex  out  ALUSEL_WIDTH  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
- ASel_ex  out  2  0 = rs1, 1 = PC, 2 = zero (LUI)
- BSel_ex  out  1  0 = rs2, 1 = immediate
- BrUn_ex  out  1  unsigned compare (BLTU/BGEU)
- PCSel_ex  out  1  1 = redirect PC to the EX ALU result
- fwd_a_ex, fwd_b_ex  out  2 each  00 = register file, 01 = EX/MEM value (muxed by WBSel_mem), 10 = WB value
- MemRW_mem  out  1  1 = store
- WBSel_mem, WBSel_wb  out  2 each  0 = memory, 1 = ALU, 2 = PC+4
- RegWEn_wb  out  1  register-file write enable
- rd_wb  out  5  register-file write address
- stall  out  1  hold PC and IF/ID
- flush  out  1  replace IF/ID with NOP

## Operation
- **Decode in ID.** Supported: R-type, I-ALU, LW, SW, BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL, JALR, LUI, AUIPC. Any other opcode decodes to the bubble bundle.
- **Bubble bundle.** RegWEn=0, MemRW=0, branch=0, jump=0, rd=0, all other fields 0.
- **ALU decode.**
  - R-type uses funct3 and inst[30].
  - I-ALU uses funct3, plus inst[30] only for shifts.
  - Loads, stores, AUIPC, LUI, JAL and JALR use ADD.
  - Branch compare is done by the comparator; the ALU computes PC + imm with ASel=1.
- **Register usage.**
  - rs1 is used by R, I-ALU, LW, SW, branches and JALR.
  - rs2 is used by R, SW and branches.
  - rd is written by R, I-ALU, LW, JAL, JALR, LUI and AUIPC.
- **Branch resolution in EX.**
  - PCSel_ex = jump_ex | (branch_ex & cond). cond is selected by funct3_ex: BEQ=BrEq, BNE=~BrEq, BLT/BLTU=BrLT, BGE/BGEU=~BrLT.
  - flush = PCSel_ex.
  - When flush=1, the ID/EX register loads the bubble on the next edge.
- **Forwarding (FWD_EN=1), per operand.**
  - 01 when RegWEn_mem and rd_mem != 0 and rd_mem == rs_ex.
  - Else 10 when RegWEn_wb and rd_wb != 0 and rd_wb == rs_ex.
  - Else 00. MEM has priority over WB.
- **Load-use stall (FWD_EN=1).** Raised when the EX instruction is LW and rd_ex != 0 and rd_ex matches a used rs of ID.
- **Stall-only mode (FWD_EN=0).** Raised when any used rs of ID (nonzero) matches rd_ex with RegWEn_ex, or rd_mem with RegWEn_mem. The register file writes before reading, so a WB match never stalls.
- **During a stall.** ID/EX loads the bubble; the ID instruction is held by the datapath and re-decoded next cycle.
- **Stall/flush priority.** stall = hazard & ~flush. Flush wins, because the ID instruction is wrong-path.
- **Pipeline advance.** EX/MEM and MEM/WB always advance.

## Timing
- ImmSel_id, stall and flush are combinational from the current inputs and registers.
- An instruction in ID in cycle n has its EX controls valid in n+1, MEM in n+2 and WB in n+3.
- One load-use stall costs exactly 1 cycle. A taken branch or jump costs 2 cycles (the IF/ID and ID/EX contents are squashed).
- Reset: rst_n low asynchronously clears all three pipeline registers to the bubble bundle. All registered outputs are 0 (PCSel_ex, MemRW_mem, RegWEn_wb, rd_wb, fwd_*, ALUSel_ex, etc.), and stall and flush are 0.
- Reset mid-operation discards all in-flight controls; there is no partial write.
- A flushed or stalled bubble never asserts RegWEn_wb or MemRW_mem.

## Test plan
- **Reset:** drive rst_n low mid-stream after a SW is in MEM → MemRW_mem and RegWEn_wb fall to 0 immediately, without waiting for a clock edge, and all outputs are 0 until release.
- **EX/MEM forwarding:** ADD x3,x1,x2 then SUB x4,x3,x1 → in the cycle SUB is in EX, fwd_a_ex=01, fwd_b_ex=00, ALUSel_ex=1. Three cycles later: RegWEn_wb=1, rd_wb=4.
- **Load-use:** LW x5,0(x1) then ADD x6,x2,x5 → stall=1 for exactly one cycle, a bubble is in EX the next cycle, then fwd_b_ex=10 when ADD is in EX.
- **Branch:**
  - BEQ in EX with BrEq=1 → PCSel_ex=1 and flush=1 for one cycle; the two younger instructions never produce RegWEn_wb=1.
  - BNE with BrEq=1 → PCSel_ex=0.
  - BLTU → BrUn_ex=1.
- **FWD_EN=0:** ADDI x3,x0,1 then ADD x4,x3,x3 → stall=1 for two consecutive cycles, and fwd_* stays 00 throughout.
- **x0 and illegal:**
  - ADDI x0,x0,1 then ADD x1,x0,x0 → no forward and no stall.
  - Opcode 7'b1111111 → RegWEn_wb=0 and MemRW_mem=0 for that instruction.
